// File: rtl/rb_pkg.sv
// rtl/rb_pkg.sv - shared constants, write-entry type and FSM states for the register-bank write initiator
package rb_pkg;

  localparam int RB_AW    = 5;
  localparam int RB_DW    = 32;
  localparam int RB_DEPTH = 4;

  typedef struct packed {
    logic [RB_AW-1:0] addr;
    logic [RB_DW-1:0] data;
  } rb_wr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PAUSE = 2'd2
  } rb_state_e;

endpackage

// File: rtl/rb_write_initiator_if.sv
// rtl/rb_write_initiator_if.sv - writeback request channel (valid/ready, dest, data)
// Signals:
//   in_valid  request valid             (master -> slave)
//   in_ready  slave can accept          (slave -> master)
//   in_wr     destination register      (master -> slave)
//   in_wd     write data                (master -> slave)
interface rb_write_initiator_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_wr;
  logic [DW-1:0] in_wd;

  modport master (output in_valid, output in_wr, output in_wd, input in_ready);
  modport slave  (input in_valid, input in_wr, input in_wd, output in_ready);
endinterface

// File: rtl/rb_wq_fifo.sv
// rtl/rb_wq_fifo.sv - DEPTH-entry circular write queue exposing every slot for bypass lookup
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   push/push_addr/data    enqueue one entry (ignored when full and not popping)
//   pop                    dequeue head (ignored when empty)
//   flush                  empty the queue; overrides push and pop
//   head_addr/head_data    oldest entry
//   count                  number of valid entries
//   wr_ptr                 next write slot; walking forward from it visits oldest..youngest
//   ent_valid/addr/data    raw slot contents
module rb_wq_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [CW-1:0]            count,
  output logic [PW-1:0]            wr_ptr,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH-1:0][AW-1:0] ent_addr,
  output logic [DEPTH-1:0][DW-1:0] ent_data
);

  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);
  // A push into a full queue is only legal when the head leaves on the same edge.
  assign do_push = push && !flush && (!full || do_pop);

  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_addr  <= '0;
      ent_data  <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (do_pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      // Placed after the pop so a full push+pop into the same slot leaves it valid.
      if (do_push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= push_addr;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rb_write_initiator.sv
// rtl/rb_write_initiator.sv - register-bank write initiator: request queue, one write per cycle, read bypass
// Optional feature macro: RB_ZERO_DROP_EN (writes to register 0 are accepted but discarded).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req (slave)           writeback requests in_valid/in_ready/in_wr/in_wd
//   drain_en              permit issuing to the bank this cycle
//   flush                 discard all queued, not yet issued entries
//   RW/wR/wD              registered bank write port, RW pulses once per write
//   q1_addr/hit/data      bypass lookup 1, youngest pending queued write wins
//   q2_addr/hit/data      bypass lookup 2
//   count                 queued entries
module rb_write_initiator
  import rb_pkg::*;
#(
  parameter int DEPTH = RB_DEPTH,
  parameter int AW    = RB_AW,
  parameter int DW    = RB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rb_write_initiator_if.slave  req,
  input  logic                 drain_en,
  input  logic                 flush,
  output logic                 RW,
  output logic [AW-1:0]        wR,
  output logic [DW-1:0]        wD,
  input  logic [AW-1:0]        q1_addr,
  output logic                 q1_hit,
  output logic [DW-1:0]        q1_data,
  input  logic [AW-1:0]        q2_addr,
  output logic                 q2_hit,
  output logic [DW-1:0]        q2_data,
  output logic [CW-1:0]        count
);

  rb_state_e                state_q;
  rb_state_e                state_d;
  logic                     keep;
  logic                     push;
  logic                     issue;
  logic [CW-1:0]            count_nxt;
  logic [AW-1:0]            head_addr;
  logic [DW-1:0]            head_data;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            idx;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;

  // Not pop-aware: a full queue refuses even if it is draining this cycle.
  assign req.in_ready = (count < CW'(DEPTH));

`ifdef RB_ZERO_DROP_EN
  // Register 0 is hard-wired; the handshake completes but nothing is queued.
  assign keep = (req.in_wr != '0);
`else
  assign keep = 1'b1;
`endif

  // flush wins over a same-cycle push.
  assign push = req.in_valid && req.in_ready && keep && !flush;

  rb_wq_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (req.in_wr),
    .push_data (req.in_wd),
    .pop       (issue),
    .flush     (flush),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .wr_ptr    (wr_ptr),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The pop is decided from the current count so a push at edge N can issue at edge N+1
  // even while the state register still reads IDLE.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    count_nxt = count;
    case (state_q)
      ST_IDLE:  issue = drain_en && (count != '0);
      ST_ISSUE: issue = drain_en && (count != '0);
      ST_PAUSE: issue = drain_en && (count != '0);
      default:  issue = 1'b0;
    endcase
    if (flush) begin
      issue = 1'b0;
    end
    count_nxt = count + CW'(push) - CW'(issue);
    if (flush || (count_nxt == '0)) begin
      state_d = ST_IDLE;
    end else if (drain_en) begin
      state_d = ST_ISSUE;
    end else begin
      state_d = ST_PAUSE;
    end
  end

  // The popped entry leaves the queue on the same edge it lands here, so bypass never
  // reports it; readers get it from the bank instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RW <= 1'b0;
      wR <= '0;
      wD <= '0;
    end else begin
      RW <= issue;
      if (issue) begin
        wR <= head_addr;
        wD <= head_data;
      end
    end
  end

  // Walk from wr_ptr forward: empty slots first, then oldest..youngest, so the last
  // matching slot visited is the youngest pending write.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wr_ptr + PW'(k);
      if (ent_valid[idx] && (ent_addr[idx] == q1_addr)) begin
        q1_hit  = 1'b1;
        q1_data = ent_data[idx];
      end
      if (ent_valid[idx] && (ent_addr[idx] == q2_addr)) begin
        q2_hit  = 1'b1;
        q2_data = ent_data[idx];
      end
    end
`ifdef RB_ZERO_DROP_EN
    if (q1_addr == '0) begin
      q1_hit  = 1'b0;
      q1_data = '0;
    end
    if (q2_addr == '0) begin
      q2_hit  = 1'b0;
      q2_data = '0;
    end
`endif
  end

endmodule

// File: tb/tb_rb_write_initiator.sv
// tb/tb_rb_write_initiator.sv - directed self-checking bench for rb_write_initiator
module tb_rb_write_initiator;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          drain_en;
  logic          flush;
  logic          RW;
  logic [AW-1:0] wR;
  logic [DW-1:0] wD;
  logic [AW-1:0] q1_addr;
  logic          q1_hit;
  logic [DW-1:0] q1_data;
  logic [AW-1:0] q2_addr;
  logic          q2_hit;
  logic [DW-1:0] q2_data;
  logic [CW-1:0] count;

  rb_write_initiator_if #(.AW(AW), .DW(DW)) req ();

  rb_write_initiator #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .drain_en (drain_en),
    .flush    (flush),
    .RW       (RW),
    .wR       (wR),
    .wD       (wD),
    .q1_addr  (q1_addr),
    .q1_hit   (q1_hit),
    .q1_data  (q1_data),
    .q2_addr  (q2_addr),
    .q2_hit   (q2_hit),
    .q2_data  (q2_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req.in_valid = 1'b1;
    req.in_wr    = a;
    req.in_wd    = d;
    tick();
    req.in_valid = 1'b0;
  endtask

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] e;
  logic [AW-1:0]    next_a;
  logic             acc;

  initial begin
    rst_n        = 1'b0;
    drain_en     = 1'b0;
    flush        = 1'b0;
    req.in_valid = 1'b0;
    req.in_wr    = '0;
    req.in_wd    = '0;
    q1_addr      = '0;
    q2_addr      = '0;

    // reset state
    #12;
    check("rst_rw", RW, 0);
    check("rst_wr", wR, 0);
    check("rst_wd", wD, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", req.in_ready, 1);

    // single push into empty queue with drain enabled
    drain_en = 1'b1;
    q1_addr  = 5'd3;
    push_one(5'd3, 32'hA5A5A5A5);
    check("t1_count_after_push", count, 1);
    check("t1_rw_not_yet", RW, 0);
    check("t1_bypass_hit", q1_hit, 1);
    check("t1_bypass_data", q1_data, 32'hA5A5A5A5);
    tick();
    check("t1_rw", RW, 1);
    check("t1_wr", wR, 3);
    check("t1_wd", wD, 32'hA5A5A5A5);
    check("t1_count", count, 0);
    check("t1_bypass_excl", q1_hit, 0);
    tick();
    check("t1_rw_drop", RW, 0);

    // fill to full with drain held off, fifth request refused
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(AW'(10 + i), DW'(32'h100 + i));
    check("t2_count_full", count, 4);
    check("t2_ready_full", req.in_ready, 0);
    req.in_valid = 1'b1;
    req.in_wr    = 5'd20;
    req.in_wd    = 32'hDEAD;
    tick();
    tick();
    check("t2_count_held", count, 4);
    check("t2_rw_paused", RW, 0);
    req.in_valid = 1'b0;
    drain_en     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_rw", RW, 1);
      check("t2_wr", wR, 10 + i);
      check("t2_wd", wD, 32'h100 + i);
    end
    tick();
    check("t2_rw_end", RW, 0);
    check("t2_count_end", count, 0);

    // youngest-wins bypass
    drain_en = 1'b0;
    push_one(5'd7, 32'd1);
    push_one(5'd7, 32'd2);
    q1_addr = 5'd7;
    q2_addr = 5'd8;
    #1;
    check("t3_q1_hit", q1_hit, 1);
    check("t3_q1_data", q1_data, 2);
    check("t3_q2_hit", q2_hit, 0);
    check("t3_q2_data", q2_data, 0);
    drain_en = 1'b1;
    tick();
    check("t3_rw1_wd", wD, 1);
    check("t3_q1_still", q1_data, 2);
    tick();
    check("t3_rw2_wd", wD, 2);
    check("t3_q1_gone", q1_hit, 0);
    tick();
    check("t3_rw_end", RW, 0);

    // full queue drained while requests keep arriving
    drain_en = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      push_one(AW'(i), DW'(32'h40 + i));
      exp_q.push_back({AW'(i), DW'(32'h40 + i)});
    end
    check("t4_count_full", count, 4);
    drain_en = 1'b1;
    next_a   = 5'd5;
    for (int c = 0; c < 6; c++) begin
      req.in_valid = 1'b1;
      req.in_wr    = next_a;
      req.in_wd    = 32'h40 + DW'(next_a);
      acc          = (exp_q.size() < DEPTH);
      check("t4_ready", req.in_ready, acc);
      e = exp_q.pop_front();
      if (acc) begin
        exp_q.push_back({next_a, 32'h40 + DW'(next_a)});
        next_a = next_a + 1'b1;
      end
      tick();
      check("t4_rw", RW, 1);
      check("t4_wr", wR, e[AW+DW-1:DW]);
      check("t4_wd", wD, e[DW-1:0]);
      check("t4_count", count, exp_q.size());
    end
    req.in_valid = 1'b0;
    for (int c = 0; c < DEPTH && exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      tick();
      check("t4_tail_wr", wR, e[AW+DW-1:DW]);
      check("t4_tail_wd", wD, e[DW-1:0]);
    end
    tick();
    check("t4_rw_end", RW, 0);
    check("t4_count_end", count, 0);

    // flush with a same-cycle push; the write already on the port completes
    drain_en = 1'b0;
    push_one(5'd21, 32'h21);
    push_one(5'd22, 32'h22);
    push_one(5'd23, 32'h23);
    drain_en = 1'b1;
    tick();
    check("t5_rw_before", RW, 1);
    check("t5_wr_before", wR, 21);
    flush        = 1'b1;
    req.in_valid = 1'b1;
    req.in_wr    = 5'd24;
    req.in_wd    = 32'h24;
    tick();
    flush        = 1'b0;
    req.in_valid = 1'b0;
    q1_addr      = 5'd24;
    q2_addr      = 5'd22;
    #1;
    check("t5_count", count, 0);
    check("t5_rw", RW, 0);
    check("t5_push_dropped", q1_hit, 0);
    check("t5_q_dropped", q2_hit, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_rw", RW, 0);
    end

    // asynchronous reset mid-drain
    drain_en = 1'b0;
    push_one(5'd1, 32'h11);
    push_one(5'd2, 32'h22);
    push_one(5'd3, 32'h33);
    drain_en = 1'b1;
    tick();
    check("t6_rw_pre", RW, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rw_async", RW, 0);
    check("t6_count_async", count, 0);
    check("t6_wr_async", wR, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_rw_after", RW, 0);
    check("t6_count_after", count, 0);
    check("t6_ready_after", req.in_ready, 1);

    // write to register 0
    q1_addr = 5'd0;
    push_one(5'd0, 32'd5);
`ifdef RB_ZERO_DROP_EN
    check("t7_count", count, 0);
    check("t7_hit", q1_hit, 0);
    tick();
    check("t7_rw", RW, 0);
    tick();
    check("t7_rw_late", RW, 0);
`else
    check("t7_count", count, 1);
    check("t7_hit", q1_hit, 1);
    tick();
    check("t7_rw", RW, 1);
    check("t7_wr", wR, 0);
    check("t7_wd", wD, 5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
